// File: rtl/layer_compositor.sv
// Per-pixel layer compositor: priority arbitration of painter layers with frame-aligned
// enable shadowing and a frame-counted flash recolour of one layer.
module layer_compositor #(
  parameter int          NUM_LAYERS   = 4,
  parameter logic [5:0]  BG_COLOR     = 6'b000000,
  parameter int          FLASH_LAYER  = 0,
  parameter logic [5:0]  FLASH_COLOR  = 6'b000011,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    display_on,
  input  logic [NUM_LAYERS-1:0]   layer_hit,
  input  logic [6*NUM_LAYERS-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]   layer_en,
  input  logic                    flash_trigger,
  output logic [5:0]              pixel_color,
  output logic                    pixel_valid,
  output logic                    flashing
);

  localparam int         IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

  flash_state_t          state;
  flash_state_t          state_next;
  logic [7:0]            flash_count;
  logic [7:0]            flash_count_next;
  logic [NUM_LAYERS-1:0] en_shadow;
  logic [NUM_LAYERS-1:0] en_eff;
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [5:0]            win_color;
  logic [5:0]            color_next;

  // Enable shadow: reloaded only at frame start so a frame never shows a partial change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_shadow <= {NUM_LAYERS{1'b1}};
    end else if (frame_start) begin
      en_shadow <= layer_en;
    end else begin
      en_shadow <= en_shadow;
    end
  end

  // The frame_start pixel already sees the enables being loaded
  always_comb begin
    if (frame_start) begin
      en_eff = layer_en;
    end else begin
      en_eff = en_shadow;
    end
  end

  // Priority pick: scanning downward leaves the lowest active index as winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = {IDX_W{1'b0}};
    win_color = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i] && en_eff[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_color = layer_color[6*i +: 6];
      end else begin
        win_found = win_found;
      end
    end
  end

  // Output colour selection including the flash substitution
  always_comb begin
    color_next = 6'b000000;
    if (!display_on) begin
      color_next = 6'b000000;
    end else if (!win_found) begin
      color_next = BG_COLOR;
    end else if ((state == FLASH) && (win_idx == IDX_W'(FLASH_LAYER))) begin
      color_next = FLASH_COLOR;
    end else begin
      color_next = win_color;
    end
  end

  // Flash FSM next state; a retrigger reload takes precedence over the frame decrement
  always_comb begin
    state_next       = state;
    flash_count_next = flash_count;
    case (state)
      IDLE: begin
        if (flash_trigger) begin
          state_next       = FLASH;
          flash_count_next = FLASH_LOAD;
        end else begin
          state_next       = IDLE;
        end
      end
      FLASH: begin
        if (flash_trigger) begin
          flash_count_next = FLASH_LOAD;
        end else if (frame_start && (flash_count != 8'd0)) begin
          flash_count_next = flash_count - 8'd1;
          if (flash_count == 8'd1) begin
            state_next = IDLE;
          end else begin
            state_next = FLASH;
          end
        end else begin
          flash_count_next = flash_count;
        end
      end
      default: begin
        state_next       = IDLE;
        flash_count_next = 8'd0;
      end
    endcase
  end

  // Flash FSM state and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      flash_count <= 8'd0;
    end else begin
      state       <= state_next;
      flash_count <= flash_count_next;
    end
  end

  // Registered outputs; flashing is loaded with the next state so it tracks state exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_color <= 6'b000000;
      pixel_valid <= 1'b0;
      flashing    <= 1'b0;
    end else begin
      pixel_color <= color_next;
      pixel_valid <= display_on;
      flashing    <= (state_next == FLASH);
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed self-checking bench for layer_compositor: arbitration, enable shadow,
// flash lifecycle, retrigger and asynchronous reset.
module tb_layer_compositor;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        display_on;
  logic [3:0]  layer_hit;
  logic [23:0] layer_color;
  logic [3:0]  layer_en;
  logic        flash_trigger;
  logic [5:0]  pixel_color;
  logic        pixel_valid;
  logic        flashing;

  int checks = 0;
  int errors = 0;

  layer_compositor dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .display_on   (display_on),
    .layer_hit    (layer_hit),
    .layer_color  (layer_color),
    .layer_en     (layer_en),
    .flash_trigger(flash_trigger),
    .pixel_color  (pixel_color),
    .pixel_valid  (pixel_valid),
    .flashing     (flashing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset         = 1'b1;
    frame_start   = 1'b0;
    display_on    = 1'b0;
    layer_hit     = 4'b0000;
    layer_en      = 4'b1111;
    flash_trigger = 1'b0;
    // L3=15 L2=30 L1=0C L0=3F
    layer_color   = {6'h15, 6'h30, 6'h0C, 6'h3F};
    #12;
    check("reset_color", {2'b00, pixel_color}, 8'h00);
    check("reset_valid", {7'd0, pixel_valid}, 8'h00);
    check("reset_flashing", {7'd0, flashing}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Basic arbitration
    display_on = 1'b1;
    layer_hit  = 4'b0110;
    tick();
    check("prio_l1", {2'b00, pixel_color}, 8'h0C);
    check("prio_valid", {7'd0, pixel_valid}, 8'h01);
    layer_hit = 4'b0000;
    tick();
    check("no_hit_bg", {2'b00, pixel_color}, 8'h00);
    layer_hit  = 4'b1111;
    display_on = 1'b0;
    tick();
    check("blank_color", {2'b00, pixel_color}, 8'h00);
    check("blank_valid", {7'd0, pixel_valid}, 8'h00);
    layer_hit  = 4'b1000;
    display_on = 1'b1;
    tick();
    check("prio_l3", {2'b00, pixel_color}, 8'h15);

    // Enable shadow
    layer_en  = 4'b1110;
    layer_hit = 4'b0001;
    tick();
    check("shadow_midframe", {2'b00, pixel_color}, 8'h3F);
    frame_start = 1'b1;
    tick();
    check("shadow_fs_cycle", {2'b00, pixel_color}, 8'h00);
    frame_start = 1'b0;
    tick();
    check("shadow_after_fs", {2'b00, pixel_color}, 8'h00);
    layer_en = 4'b1111;
    tick();
    check("shadow_hold", {2'b00, pixel_color}, 8'h00);
    frame_start = 1'b1;
    tick();
    check("shadow_reenable", {2'b00, pixel_color}, 8'h3F);
    frame_start = 1'b0;

    // Flash lifecycle
    flash_trigger = 1'b1;
    tick();
    flash_trigger = 1'b0;
    check("flash_start", {7'd0, flashing}, 8'h01);
    check("flash_first_pix", {2'b00, pixel_color}, 8'h3F);
    tick();
    check("flash_color", {2'b00, pixel_color}, 8'h03);
    layer_hit = 4'b0010;
    tick();
    check("flash_other_layer", {2'b00, pixel_color}, 8'h0C);
    layer_hit = 4'b0011;
    tick();
    check("flash_l0_over_l1", {2'b00, pixel_color}, 8'h03);
    layer_hit = 4'b0001;
    for (int i = 0; i < 7; i++) frame_pulse();
    check("flash_after7", {7'd0, flashing}, 8'h01);
    check("flash_after7_pix", {2'b00, pixel_color}, 8'h03);
    frame_pulse();
    check("flash_after8", {7'd0, flashing}, 8'h00);
    check("flash_end_pix", {2'b00, pixel_color}, 8'h3F);

    // Retrigger mid-flash
    flash_trigger = 1'b1;
    tick();
    flash_trigger = 1'b0;
    for (int i = 0; i < 5; i++) frame_pulse();
    flash_trigger = 1'b1;
    tick();
    flash_trigger = 1'b0;
    for (int i = 0; i < 7; i++) frame_pulse();
    check("retrig_after7", {7'd0, flashing}, 8'h01);
    frame_pulse();
    check("retrig_after8", {7'd0, flashing}, 8'h00);

    // Trigger coincident with frame_start: reload wins
    flash_trigger = 1'b1;
    tick();
    frame_start = 1'b1;
    tick();
    flash_trigger = 1'b0;
    frame_start   = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) frame_pulse();
    check("coinc_after7", {7'd0, flashing}, 8'h01);
    frame_pulse();
    check("coinc_after8", {7'd0, flashing}, 8'h00);

    // Asynchronous reset during a flash
    flash_trigger = 1'b1;
    tick();
    flash_trigger = 1'b0;
    tick();
    check("pre_reset_pix", {2'b00, pixel_color}, 8'h03);
    #2;
    reset    = 1'b1;
    layer_en = 4'b0000;
    #1;
    check("async_rst_color", {2'b00, pixel_color}, 8'h00);
    check("async_rst_valid", {7'd0, pixel_valid}, 8'h00);
    check("async_rst_flash", {7'd0, flashing}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_all_en", {2'b00, pixel_color}, 8'h3F);
    check("post_rst_noflash", {7'd0, flashing}, 8'h00);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("post_rst_fs_en", {2'b00, pixel_color}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
